peripheral_sqrt_param: RTL and testbench

PERIPHERAL_SQRT_PARAM -- requirements
Module: peripheral_sqrt_param

---
 rtl/peripheral_sqrt_param.sv | 131 +++++++++++++
 tb/tb_peripheral_sqrt_param.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_sqrt_param.sv
// Memory-mapped integer square-root peripheral: bus-written operand, one root bit per
// cycle (non-restoring, MSB first), sticky done/overrun status and a level interrupt.
module peripheral_sqrt_param #(
   parameter int WIDTH = 16,
   parameter int RW    = WIDTH / 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d_in,
   input  logic        cs,
   input  logic [4:0]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [31:0] d_out,
   output logic        irq
);

   localparam logic [4:0] ADDR_OPERAND = 5'h04;
   localparam logic [4:0] ADDR_CTRL    = 5'h0C;
   localparam logic [4:0] ADDR_ROOT    = 5'h10;
   localparam logic [4:0] ADDR_STATUS  = 5'h14;
   localparam logic [4:0] ADDR_REM     = 5'h18;
   localparam int         CW           = (RW > 1) ? $clog2(RW) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
   state_t state, state_nx;

   logic [WIDTH-1:0] operand_r, op_w;
   logic [RW-1:0]    root_w, root_r, root_nx;
   logic [RW+1:0]    rem_w, rem_r, rem_sh, rem_nx, rem_fix;
   logic [CW-1:0]    cnt;
   logic             q_bit, irq_en, done, overrun, busy;
   logic             wr_en, rd_en, ctrl_wr, start_req, start_acc, calc_last;
   logic [31:0]      rdata;
   logic             unused_d_in;

   // Bus semantics: every edge with cs=1 is a transfer; wr wins over rd, so a
   // simultaneous rd+wr is a pure write and leaves d_out untouched.
   assign wr_en       = cs & wr;
   assign rd_en       = cs & rd & ~wr;
   assign ctrl_wr     = wr_en & (addr == ADDR_CTRL);
   assign start_req   = ctrl_wr & d_in[0];
   assign start_acc   = start_req & (state == IDLE);
   assign busy        = (state != IDLE);
   assign calc_last   = (cnt == CW'(RW - 1));
   assign irq         = done & irq_en;
   assign unused_d_in = ^d_in;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_acc) state_nx = LOAD;
         LOAD:    state_nx = CALC;
         CALC:    if (calc_last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Remainder is signed two's complement in RW+2 bits; wrap in the shift is harmless
   // because every post-step remainder lies within [-(2q+1), 2q].
   always_comb begin
      rem_sh  = {rem_w[RW-1:0], op_w[WIDTH-1 -: 2]};
      rem_nx  = rem_w[RW+1] ? rem_sh + {root_w, 2'b11} : rem_sh - {root_w, 2'b01};
      q_bit   = ~rem_nx[RW+1];
      root_nx = (root_w << 1) | RW'(q_bit);
      rem_fix = rem_w[RW+1] ? rem_w + {1'b0, root_w, 1'b1} : rem_w;
   end

   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_ROOT:   rdata[RW-1:0] = root_r;
         ADDR_STATUS: rdata[2:0]    = {overrun, busy, done};
         ADDR_REM:    rdata[RW+1:0] = rem_r;
         default:     rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         operand_r <= '0;
         op_w      <= '0;
         root_w    <= '0;
         rem_w     <= '0;
         cnt       <= '0;
         root_r    <= '0;
         rem_r     <= '0;
         irq_en    <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
         d_out     <= '0;
      end else begin
         if (wr_en && addr == ADDR_OPERAND) operand_r <= d_in[WIDTH-1:0];
         if (ctrl_wr) irq_en <= d_in[1];
         if (start_acc) begin
            done    <= 1'b0;
            overrun <= 1'b0;
         end else if (start_req) begin
            overrun <= 1'b1;
         end
         case (state)
            LOAD: begin
               op_w   <= operand_r;
               root_w <= '0;
               rem_w  <= '0;
               cnt    <= '0;
            end
            CALC: begin
               op_w   <= op_w << 2;
               root_w <= root_nx;
               rem_w  <= rem_nx;
               cnt    <= cnt + CW'(1);
            end
            DONE: begin
               root_r <= root_w;
               rem_r  <= rem_fix;
               done   <= 1'b1;
            end
            default: ;
         endcase
         if (rd_en) d_out <= rdata;
      end
   end

endmodule

// File: tb/tb_peripheral_sqrt_param.sv
// Bench for peripheral_sqrt_param: a WIDTH=16 and a WIDTH=32 instance share one bus and
// are checked against an arithmetic square-root model.
module tb_peripheral_sqrt_param;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] d_in;
   logic        cs, rd, wr;
   logic [4:0]  addr;
   logic [31:0] d_out16, d_out32;
   logic        irq16, irq32;
   int          checks = 0;
   int          failures = 0;
   longint      last_root16, last_root32;

   always #5 clk = ~clk;

   peripheral_sqrt_param #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr),
      .rd(rd), .wr(wr), .d_out(d_out16), .irq(irq16));

   peripheral_sqrt_param #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr),
      .rd(rd), .wr(wr), .d_out(d_out32), .irq(irq32));

   function automatic longint isqrt(input longint a);
      longint r;
      r = longint'($sqrt(real'(a)));
      while (r * r > a) r--;
      while ((r + 1) * (r + 1) <= a) r++;
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
      @(posedge clk);
      #1;
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] v16, output logic [31:0] v32);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
      @(posedge clk);
      #1;
      cs = 1'b0; rd = 1'b0;
      v16 = d_out16; v32 = d_out32;
   endtask

   // Full run on both instances: operand, start, latency via irq, then result readback.
   task automatic run_op(input logic [31:0] op, input bit use_irq);
      logic [31:0] v16, v32;
      longint a16, a32, r16, r32;
      int lat16, lat32;
      bit irq_seen;
      a16 = longint'(op[15:0]);
      a32 = longint'(op);
      r16 = isqrt(a16);
      r32 = isqrt(a32);
      bus_write(5'h04, op);
      bus_write(5'h0C, use_irq ? 32'h3 : 32'h1);
      checks++;
      if (irq16 !== 1'b0 || irq32 !== 1'b0) begin
         failures++;
         $display("FAIL irq_at_start op=%h got %b/%b want 0/0", op, irq16, irq32);
      end
      lat16 = -1; lat32 = -1; irq_seen = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk);
         #1;
         if (irq16 === 1'b1 && lat16 < 0) lat16 = c;
         if (irq32 === 1'b1 && lat32 < 0) lat32 = c;
         if (irq16 !== 1'b0 || irq32 !== 1'b0) irq_seen = 1'b1;
      end
      if (use_irq) begin
         checks++;
         if (lat16 != 10 || lat32 != 18) begin
            failures++;
            $display("FAIL latency op=%h got %0d/%0d want 10/18", op, lat16, lat32);
         end
      end else begin
         checks++;
         if (irq_seen) begin
            failures++;
            $display("FAIL irq_disabled op=%h got irq activity want none", op);
         end
      end
      bus_read(5'h14, v16, v32);
      checks++;
      if (v16 !== 32'h1 || v32 !== 32'h1) begin
         failures++;
         $display("FAIL status_done op=%h got %h/%h want 1/1", op, v16, v32);
      end
      bus_read(5'h10, v16, v32);
      checks++;
      if (v16 !== 32'(r16) || v32 !== 32'(r32)) begin
         failures++;
         $display("FAIL root op=%h got %0d/%0d want %0d/%0d", op, v16, v32, r16, r32);
      end
      bus_read(5'h18, v16, v32);
      checks++;
      if (v16 !== 32'(a16 - r16 * r16) || v32 !== 32'(a32 - r32 * r32)) begin
         failures++;
         $display("FAIL rem op=%h got %0d/%0d want %0d/%0d", op, v16, v32,
                  a16 - r16 * r16, a32 - r32 * r32);
      end
      last_root16 = r16;
      last_root32 = r32;
   endtask

   task automatic test_reset();
      logic [31:0] v16, v32;
      @(negedge clk);
      reset = 1'b1; cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 5'h0C; d_in = 32'h3;
      idle(3);
      @(negedge clk);
      reset = 1'b0; cs = 1'b0; wr = 1'b0;
      checks++;
      if (irq16 !== 1'b0 || irq32 !== 1'b0 || d_out16 !== 32'h0 || d_out32 !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got irq %b/%b d_out %h/%h want 0", irq16, irq32, d_out16, d_out32);
      end
      bus_read(5'h14, v16, v32);
      checks++;
      if (v16 !== 32'h0 || v32 !== 32'h0) begin
         failures++;
         $display("FAIL reset_status got %h/%h want 0/0", v16, v32);
      end
      bus_read(5'h10, v16, v32);
      checks++;
      if (v16 !== 32'h0 || v32 !== 32'h0) begin
         failures++;
         $display("FAIL reset_root got %h/%h want 0/0", v16, v32);
      end
      bus_read(5'h18, v16, v32);
      checks++;
      if (v16 !== 32'h0 || v32 !== 32'h0) begin
         failures++;
         $display("FAIL reset_rem got %h/%h want 0/0", v16, v32);
      end
   endtask

   task automatic test_corners();
      run_op(32'h0000_0441, 1'b1);
      run_op(32'hFFFF_FFFF, 1'b1);
      run_op(32'h0000_0000, 1'b1);
      run_op(32'h0000_0002, 1'b0);
      run_op(32'h0001_0000, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) run_op($urandom, 1'($urandom_range(0, 1)));
   endtask

   task automatic test_overrun();
      logic [31:0] v16, v32;
      bus_write(5'h04, 32'h0000_0441);
      bus_write(5'h0C, 32'h3);
      bus_write(5'h04, 32'hFFFF_FFFF);
      idle(1);
      bus_write(5'h0C, 32'h3);
      bus_read(5'h14, v16, v32);
      checks++;
      if (v16 !== 32'h6 || v32 !== 32'h6) begin
         failures++;
         $display("FAIL overrun_mid got %h/%h want 6/6", v16, v32);
      end
      idle(20);
      bus_read(5'h14, v16, v32);
      checks++;
      if (v16 !== 32'h5 || v32 !== 32'h5) begin
         failures++;
         $display("FAIL overrun_final got %h/%h want 5/5", v16, v32);
      end
      bus_read(5'h10, v16, v32);
      checks++;
      if (v16 !== 32'd33 || v32 !== 32'd33) begin
         failures++;
         $display("FAIL overrun_root got %0d/%0d want 33/33", v16, v32);
      end
      run_op(32'hFFFF_FFFF, 1'b1);
   endtask

   task automatic test_start_at_done();
      logic [31:0] v16, v32;
      bus_write(5'h04, 32'h0000_0064);
      bus_write(5'h0C, 32'h3);
      idle(9);
      bus_write(5'h0C, 32'h3);
      checks++;
      if (irq16 !== 1'b1) begin
         failures++;
         $display("FAIL done_edge_irq got %b want 1", irq16);
      end
      bus_read(5'h14, v16, v32);
      checks++;
      if (v16 !== 32'h5 || v32 !== 32'h6) begin
         failures++;
         $display("FAIL done_edge_status got %h/%h want 5/6", v16, v32);
      end
      idle(12);
      bus_read(5'h14, v16, v32);
      checks++;
      if (v16 !== 32'h5 || v32 !== 32'h5) begin
         failures++;
         $display("FAIL done_edge_final got %h/%h want 5/5", v16, v32);
      end
      bus_read(5'h10, v16, v32);
      checks++;
      if (v16 !== 32'd10 || v32 !== 32'd10) begin
         failures++;
         $display("FAIL done_edge_root got %0d/%0d want 10/10", v16, v32);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v16, v32;
      run_op(32'h0000_9C40, 1'b1);
      bus_write(5'h04, 32'h0000_0441);
      bus_write(5'h0C, 32'h3);
      idle(4);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (irq16 !== 1'b0 || irq32 !== 1'b0 || d_out16 !== 32'h0 || d_out32 !== 32'h0) begin
         failures++;
         $display("FAIL midreset_outputs got irq %b/%b d_out %h/%h want 0", irq16, irq32, d_out16, d_out32);
      end
      @(negedge clk);
      reset = 1'b0;
      idle(20);
      bus_read(5'h14, v16, v32);
      checks++;
      if (v16 !== 32'h0 || v32 !== 32'h0 || irq16 !== 1'b0 || irq32 !== 1'b0) begin
         failures++;
         $display("FAIL midreset_status got %h/%h irq %b/%b want 0", v16, v32, irq16, irq32);
      end
      bus_read(5'h10, v16, v32);
      checks++;
      if (v16 !== 32'h0 || v32 !== 32'h0) begin
         failures++;
         $display("FAIL midreset_root got %h/%h want 0/0", v16, v32);
      end
      run_op(32'h0000_0441, 1'b1);
   endtask

   task automatic test_irq_enable();
      logic [31:0] v16, v32;
      run_op(32'h0000_0051, 1'b0);
      bus_write(5'h0C, 32'h2);
      checks++;
      if (irq16 !== 1'b1 || irq32 !== 1'b1) begin
         failures++;
         $display("FAIL irq_en_late got %b/%b want 1/1", irq16, irq32);
      end
      bus_read(5'h14, v16, v32);
      checks++;
      if (v16 !== 32'h1 || v32 !== 32'h1) begin
         failures++;
         $display("FAIL ctrl_nostart got %h/%h want 1/1", v16, v32);
      end
      bus_write(5'h0C, 32'h0);
      checks++;
      if (irq16 !== 1'b0 || irq32 !== 1'b0) begin
         failures++;
         $display("FAIL irq_en_clear got %b/%b want 0/0", irq16, irq32);
      end
      bus_write(5'h0C, 32'h2);
      run_op(32'h1234_5678, 1'b1);
   endtask

   task automatic test_bus();
      logic [31:0] v16, v32;
      bus_read(5'h10, v16, v32);
      idle(3);
      checks++;
      if (d_out16 !== 32'(last_root16) || d_out32 !== 32'(last_root32)) begin
         failures++;
         $display("FAIL dout_hold got %h/%h want %h/%h", d_out16, d_out32, last_root16, last_root32);
      end
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 5'h14; d_in = 32'h0;
      @(posedge clk);
      #1;
      cs = 1'b0; rd = 1'b0; wr = 1'b0;
      checks++;
      if (d_out16 !== 32'(last_root16) || d_out32 !== 32'(last_root32)) begin
         failures++;
         $display("FAIL rd_wr_is_write got %h/%h want %h/%h", d_out16, d_out32, last_root16, last_root32);
      end
      bus_read(5'h08, v16, v32);
      checks++;
      if (v16 !== 32'h0 || v32 !== 32'h0) begin
         failures++;
         $display("FAIL unmapped_read got %h/%h want 0/0", v16, v32);
      end
      bus_write(5'h08, 32'h3);
      bus_read(5'h14, v16, v32);
      checks++;
      if (v16 !== 32'h1 || v32 !== 32'h1) begin
         failures++;
         $display("FAIL unmapped_write got %h/%h want 1/1", v16, v32);
      end
   endtask

   initial begin
      reset = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 5'h0; d_in = 32'h0;
      last_root16 = 0; last_root32 = 0;
      test_reset();
      test_corners();
      test_overrun();
      test_start_at_done();
      test_reset_mid();
      test_irq_enable();
      test_bus();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
